// File: rtl/mp_arith_pkg.sv
// Shared types and constants for the modular-arithmetic datapath units.
// Holds the segment-FSM state encoding and the default operand geometry.
package mp_arith_pkg;

   localparam int DEF_WIDTH = 1027;
   localparam int DEF_SEG_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int ceil_div(input int width, input int seg);
      return (width + seg - 1) / seg;
   endfunction

endpackage

// File: rtl/seg_adder_cell.sv
// One SEG_W-bit slice of the multi-precision adder: {cout, sum} = a + b + cin.
// Purely combinational; the caller owns the carry register between slices.
module seg_adder_cell #(
   parameter int SEG_W = 128
) (
   input  logic [SEG_W-1:0] i_a,
   input  logic [SEG_W-1:0] i_b,
   input  logic             i_cin,
   output logic [SEG_W-1:0] o_sum,
   output logic             o_cout
);

   assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, i_cin};

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential multi-precision adder/subtractor: one SEG_W segment per clock,
// LSB first, carry held in a register, with a start/busy/done handshake.
module mp_addsub_seq
   import mp_arith_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG_W = DEF_SEG_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             busy,
   output logic             done
);

   localparam int NSEG    = ceil_div(WIDTH, SEG_W);
   localparam int PADW    = NSEG * SEG_W;
   localparam int TOPBITS = WIDTH - (NSEG - 1) * SEG_W;
   localparam int IDXW    = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

   state_t            r_state;
   logic [PADW-1:0]   r_a;
   logic [PADW-1:0]   r_b;
   logic [WIDTH-1:0]  r_res;
   logic              r_msb;
   logic              r_carry;
   logic              r_sub;
   logic              r_busy;
   logic              r_done;
   logic [IDXW-1:0]   r_seg_idx;

   logic [SEG_W-1:0]  w_a_seg;
   logic [SEG_W-1:0]  w_b_seg;
   logic [SEG_W-1:0]  w_sum;
   logic              w_cout;
   logic [SEG_W:0]    w_ext;

   assign w_a_seg = r_a[r_seg_idx * SEG_W +: SEG_W];
   assign w_b_seg = r_b[r_seg_idx * SEG_W +: SEG_W];
   assign w_ext   = {w_cout, w_sum};

   seg_adder_cell #(
      .SEG_W (SEG_W)
   ) u_cell (
      .i_a    (w_a_seg),
      .i_b    (w_b_seg),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // The operands are zero-padded after the B inversion, so the top partial
   // segment's bit TOPBITS is exactly the carry out of bit WIDTH-1.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_res     <= '0;
         r_msb     <= 1'b0;
         r_carry   <= 1'b0;
         r_sub     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_seg_idx <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a       <= PADW'(in_a);
                  r_b       <= PADW'(in_b ^ {WIDTH{subtract}});
                  r_sub     <= subtract;
                  r_carry   <= subtract;
                  r_seg_idx <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               for (int i = 0; i < WIDTH; i++) begin
                  if (r_seg_idx == IDXW'(i / SEG_W)) begin
                     r_res[i] <= w_sum[i % SEG_W];
                  end
               end
               r_carry <= w_cout;
               if (r_seg_idx == LAST_IDX) begin
                  r_msb     <= w_ext[TOPBITS] ^ r_sub;
                  r_seg_idx <= '0;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_seg_idx <= r_seg_idx + IDXW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign result = {r_msb, r_res};
   assign busy   = r_busy;
   assign done   = r_done;

endmodule
